// File: rtl/video_fetch_pkg.sv
// Shared types and constants for the video fetch path.
package video_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BMP      = 3'd1,
    ATTR     = 3'd2,
    UP_INK   = 3'd3,
    UP_PAPER = 3'd4,
    DRAIN    = 3'd5,
    DONE     = 3'd6
  } fetch_state_t;

  localparam logic [1:0]  SLOT_BMP        = 2'd0;
  localparam logic [1:0]  SLOT_ATTR       = 2'd1;
  localparam logic [1:0]  SLOT_INK        = 2'd2;
  localparam logic [1:0]  SLOT_PAPER      = 2'd3;
  localparam logic [12:0] VIDEO_ATTR_BASE = 13'h1800;

  // Buffer slot filled by the read a requesting state issues.
  function automatic logic [1:0] state_slot(input fetch_state_t s);
    logic [1:0] slot;
    case (s)
      BMP:      slot = SLOT_BMP;
      ATTR:     slot = SLOT_ATTR;
      UP_INK:   slot = SLOT_INK;
      UP_PAPER: slot = SLOT_PAPER;
      default:  slot = SLOT_BMP;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/video_fetch_addr.sv
// ZX screen address mapping: bitmap, attribute and ULA+ palette indices.
module video_fetch_addr
  import video_fetch_pkg::*;
#(
  parameter logic [12:0] ATTR_BASE = VIDEO_ATTR_BASE
) (
  input  logic [7:0]  line,
  input  logic [4:0]  col,
  input  logic [7:0]  attr_byte,
  output logic [14:0] bmp_addr,
  output logic [14:0] attr_addr,
  output logic [14:0] ink_addr,
  output logic [14:0] paper_addr
);

  logic [12:0] attr_off;

  // Bitmap rows are interleaved: third, pixel row, character row, column.
  assign bmp_addr   = {2'b00, line[7:6], line[2:0], line[5:3], col};
  assign attr_off   = ATTR_BASE + {3'b000, line[7:3], col};
  assign attr_addr  = {2'b00, attr_off};
  // Palette index: CLUT select (bright/flash bits), ink/paper flag, colour.
  assign ink_addr   = {9'd0, attr_byte[7:6], 1'b0, attr_byte[2:0]};
  assign paper_addr = {9'd0, attr_byte[7:6], 1'b1, attr_byte[5:3]};

endmodule

// File: rtl/video_fetch.sv
// Per-cell video fetch requester with double-buffered display bytes.
module video_fetch
  import video_fetch_pkg::*;
#(
  parameter bit          FETCH_UP  = 1'b1,
  parameter logic [12:0] ATTR_BASE = VIDEO_ATTR_BASE
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [7:0]  line,
  input  logic [4:0]  col,
  input  logic        load,
  input  logic        up_en,
  output logic        video_read_req,
  output logic        video_read_req_is_up,
  output logic [14:0] video_read_addr,
  input  logic        video_read_req_ack,
  input  logic        video_data_valid,
  input  logic [7:0]  vd,
  output logic [7:0]  bitmap,
  output logic [7:0]  attr,
  output logic [7:0]  ink_up,
  output logic [7:0]  paper_up,
  output logic        underrun,
  input  logic        underrun_clr
);

  fetch_state_t state, state_n;
  logic [7:0]  line_r;
  logic [4:0]  col_r;
  logic        up_r;
  logic [7:0]  fbuf [4];
  logic [1:0]  pend_slot;
  logic        pend_valid;
  logic        complete;
  logic        attr_captured;

  logic        ack_hit, valid_hit, up_mode;
  logic [1:0]  last_slot;
  logic [7:0]  line_s;
  logic [4:0]  col_s;
  logic [14:0] bmp_addr, attr_addr, ink_addr, paper_addr;
  logic        req_n, is_up_n;
  logic [14:0] addr_n;
  logic [7:0]  byte_bmp, byte_attr, byte_ink, byte_paper;
  logic        complete_now, underrun_set;

  assign ack_hit   = video_read_req & video_read_req_ack;
  assign valid_hit = video_data_valid & pend_valid;
  assign up_mode   = (FETCH_UP != 1'b0) && up_r;
  assign last_slot = up_mode ? SLOT_PAPER : SLOT_ATTR;

  // The BMP request is issued on the fetch_start edge, before line/col land in their registers.
  assign line_s = fetch_start ? line : line_r;
  assign col_s  = fetch_start ? col  : col_r;

  video_fetch_addr #(.ATTR_BASE(ATTR_BASE)) u_addr (
    .line       (line_s),
    .col        (col_s),
    .attr_byte  (fbuf[SLOT_ATTR]),
    .bmp_addr   (bmp_addr),
    .attr_addr  (attr_addr),
    .ink_addr   (ink_addr),
    .paper_addr (paper_addr)
  );

  // Bypass lets a load see the byte arriving in the same cycle.
  assign byte_bmp   = (valid_hit && pend_slot == SLOT_BMP)   ? vd : fbuf[SLOT_BMP];
  assign byte_attr  = (valid_hit && pend_slot == SLOT_ATTR)  ? vd : fbuf[SLOT_ATTR];
  assign byte_ink   = (valid_hit && pend_slot == SLOT_INK)   ? vd : fbuf[SLOT_INK];
  assign byte_paper = (valid_hit && pend_slot == SLOT_PAPER) ? vd : fbuf[SLOT_PAPER];

  assign complete_now = complete || (state == DRAIN && valid_hit && pend_slot == last_slot);
  assign underrun_set = (load && !complete_now) ||
                        (fetch_start && state != IDLE && state != DONE);

  // State register.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: requests advance on ack, drain waits for the last slot's data.
  always_comb begin
    state_n = state;
    if (fetch_start) begin
      state_n = BMP;
    end else begin
      case (state)
        BMP:      if (ack_hit) state_n = ATTR;     else state_n = state;
        ATTR:     if (ack_hit) state_n = up_mode ? UP_INK : DRAIN; else state_n = state;
        UP_INK:   if (ack_hit) state_n = UP_PAPER; else state_n = state;
        UP_PAPER: if (ack_hit) state_n = DRAIN;    else state_n = state;
        DRAIN:    if (valid_hit && pend_slot == last_slot) state_n = DONE; else state_n = state;
        default:  state_n = state;
      endcase
    end
  end

  // Request for the coming cycle; the ink read waits for the attribute byte.
  always_comb begin
    req_n   = 1'b0;
    is_up_n = 1'b0;
    addr_n  = video_read_addr;
    case (state_n)
      BMP:      begin req_n = 1'b1;          addr_n = bmp_addr;                  end
      ATTR:     begin req_n = 1'b1;          addr_n = attr_addr;                 end
      UP_INK:   begin req_n = attr_captured; addr_n = ink_addr;   is_up_n = 1'b1; end
      UP_PAPER: begin req_n = 1'b1;          addr_n = paper_addr; is_up_n = 1'b1; end
      default:  begin req_n = 1'b0;          addr_n = video_read_addr;           end
    endcase
  end

  // Registered request outputs.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      video_read_req       <= 1'b0;
      video_read_req_is_up <= 1'b0;
      video_read_addr      <= 15'd0;
    end else begin
      video_read_req       <= req_n;
      video_read_req_is_up <= is_up_n;
      video_read_addr      <= addr_n;
    end
  end

  // Pending-slot tracking and fetch buffer fill.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      pend_slot  <= SLOT_BMP;
      pend_valid <= 1'b0;
      for (int i = 0; i < 4; i++) fbuf[i] <= 8'h00;
    end else begin
      if (ack_hit) begin
        pend_slot  <= state_slot(state);
        pend_valid <= 1'b1;
      end else if (valid_hit) begin
        pend_valid <= 1'b0;
      end
      if (valid_hit) fbuf[pend_slot] <= vd;
    end
  end

  // Cell context latched at fetch_start, plus completion flags.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      line_r        <= 8'd0;
      col_r         <= 5'd0;
      up_r          <= 1'b0;
      complete      <= 1'b0;
      attr_captured <= 1'b0;
    end else if (fetch_start) begin
      line_r        <= line;
      col_r         <= col;
      up_r          <= up_en;
      complete      <= 1'b0;
      attr_captured <= 1'b0;
    end else begin
      if (state_n == DONE) complete <= 1'b1;
      if (valid_hit && pend_slot == SLOT_ATTR) attr_captured <= 1'b1;
    end
  end

  // Display registers and sticky underrun (set beats clear).
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      bitmap   <= 8'h00;
      attr     <= 8'h00;
      ink_up   <= 8'h00;
      paper_up <= 8'h00;
      underrun <= 1'b0;
    end else begin
      if (load) begin
        bitmap   <= byte_bmp;
        attr     <= byte_attr;
        ink_up   <= byte_ink;
        paper_up <= byte_paper;
      end
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_fetch.sv
// Directed self-checking bench for video_fetch; the bench plays the arbiter.
module tb_video_fetch;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [7:0]  line;
  logic [4:0]  col;
  logic        load;
  logic        up_en;
  logic        video_read_req;
  logic        video_read_req_is_up;
  logic [14:0] video_read_addr;
  logic        video_read_req_ack;
  logic        video_data_valid;
  logic [7:0]  vd;
  logic [7:0]  bitmap, attr, ink_up, paper_up;
  logic        underrun;
  logic        underrun_clr;

  int checks = 0;
  int errors = 0;

  video_fetch dut (
    .clk28                (clk28),
    .rst                  (rst),
    .fetch_start          (fetch_start),
    .line                 (line),
    .col                  (col),
    .load                 (load),
    .up_en                (up_en),
    .video_read_req       (video_read_req),
    .video_read_req_is_up (video_read_req_is_up),
    .video_read_addr      (video_read_addr),
    .video_read_req_ack   (video_read_req_ack),
    .video_data_valid     (video_data_valid),
    .vd                   (vd),
    .bitmap               (bitmap),
    .attr                 (attr),
    .ink_up               (ink_up),
    .paper_up             (paper_up),
    .underrun             (underrun),
    .underrun_clr         (underrun_clr)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_start = 1'b0; line = 8'd0; col = 5'd0; load = 1'b0;
    up_en = 1'b0; video_read_req_ack = 1'b0; video_data_valid = 1'b0;
    vd = 8'h00; underrun_clr = 1'b0;
    step(); step();
    chk("rst_req", {15'd0, video_read_req}, 16'h0000);
    chk("rst_addr", {1'b0, video_read_addr}, 16'h0000);
    chk("rst_bitmap", {8'd0, bitmap}, 16'h0000);
    chk("rst_underrun", {15'd0, underrun}, 16'h0000);
    rst = 1'b0;
    step();

    // Cell line 0 col 0, no palette, immediate acks.
    fetch_start = 1'b1; line = 8'd0; col = 5'd0; up_en = 1'b0;
    step(); fetch_start = 1'b0;
    chk("t1_bmp_req", {15'd0, video_read_req}, 16'h0001);
    chk("t1_bmp_addr", {1'b0, video_read_addr}, 16'h0000);
    chk("t1_bmp_isup", {15'd0, video_read_req_is_up}, 16'h0000);
    video_read_req_ack = 1'b1;
    step();
    chk("t1_attr_addr", {1'b0, video_read_addr}, 16'h1800);
    video_data_valid = 1'b1; vd = 8'hAA;
    step();
    chk("t1_drain_req", {15'd0, video_read_req}, 16'h0000);
    video_read_req_ack = 1'b0; vd = 8'h38;
    step();
    video_data_valid = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    chk("t1_bitmap", {8'd0, bitmap}, 16'h00AA);
    chk("t1_attr", {8'd0, attr}, 16'h0038);
    chk("t1_underrun", {15'd0, underrun}, 16'h0000);

    // Line 65 col 3; load coincides with the final valid (bypass).
    fetch_start = 1'b1; line = 8'd65; col = 5'd3;
    step(); fetch_start = 1'b0;
    chk("t2_bmp_addr", {1'b0, video_read_addr}, 16'h0903);
    video_read_req_ack = 1'b1;
    step();
    chk("t2_attr_addr", {1'b0, video_read_addr}, 16'h1903);
    video_data_valid = 1'b1; vd = 8'h11;
    step();
    video_read_req_ack = 1'b0; vd = 8'h22; load = 1'b1;
    step(); load = 1'b0; video_data_valid = 1'b0;
    chk("t2_bitmap", {8'd0, bitmap}, 16'h0011);
    chk("t2_attr_bypass", {8'd0, attr}, 16'h0022);
    chk("t2_underrun", {15'd0, underrun}, 16'h0000);

    // ULA+ cell, attribute 0xC5.
    fetch_start = 1'b1; line = 8'd0; col = 5'd0; up_en = 1'b1;
    step(); fetch_start = 1'b0;
    video_read_req_ack = 1'b1;
    step();
    video_data_valid = 1'b1; vd = 8'h55;
    step();
    chk("t3_ink_wait_req", {15'd0, video_read_req}, 16'h0000);
    video_read_req_ack = 1'b0; vd = 8'hC5;
    step();
    chk("t3_bubble_req", {15'd0, video_read_req}, 16'h0000);
    video_data_valid = 1'b0;
    step();
    chk("t3_ink_req", {15'd0, video_read_req}, 16'h0001);
    chk("t3_ink_isup", {15'd0, video_read_req_is_up}, 16'h0001);
    chk("t3_ink_addr", {1'b0, video_read_addr}, 16'h0035);
    video_read_req_ack = 1'b1;
    step();
    chk("t3_paper_addr", {1'b0, video_read_addr}, 16'h0038);
    chk("t3_paper_isup", {15'd0, video_read_req_is_up}, 16'h0001);
    video_data_valid = 1'b1; vd = 8'h1F;
    step();
    chk("t3_drain_req", {15'd0, video_read_req}, 16'h0000);
    video_read_req_ack = 1'b0; vd = 8'hE0;
    step();
    video_data_valid = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    chk("t3_bitmap", {8'd0, bitmap}, 16'h0055);
    chk("t3_attr", {8'd0, attr}, 16'h00C5);
    chk("t3_ink", {8'd0, ink_up}, 16'h001F);
    chk("t3_paper", {8'd0, paper_up}, 16'h00E0);
    chk("t3_underrun", {15'd0, underrun}, 16'h0000);

    // BMP ack held off for 5 cycles.
    fetch_start = 1'b1; line = 8'd0; col = 5'd0; up_en = 1'b0;
    step(); fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_req", {15'd0, video_read_req}, 16'h0001);
      chk("t4_hold_addr", {1'b0, video_read_addr}, 16'h0000);
      step();
    end
    video_read_req_ack = 1'b1;
    step();
    chk("t4_attr_addr", {1'b0, video_read_addr}, 16'h1800);
    video_data_valid = 1'b1; vd = 8'h77;
    step();
    video_read_req_ack = 1'b0; vd = 8'h66;
    step();
    video_data_valid = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    chk("t4_bitmap", {8'd0, bitmap}, 16'h0077);
    chk("t4_attr", {8'd0, attr}, 16'h0066);
    chk("t4_ink_kept", {8'd0, ink_up}, 16'h001F);

    // Load while still in ATTR; clear in the same cycle loses to the set.
    fetch_start = 1'b1;
    step(); fetch_start = 1'b0;
    video_read_req_ack = 1'b1;
    step();
    video_read_req_ack = 1'b0; video_data_valid = 1'b1; vd = 8'h99;
    step();
    video_data_valid = 1'b0; load = 1'b1; underrun_clr = 1'b1;
    step(); load = 1'b0;
    chk("t5_underrun_set", {15'd0, underrun}, 16'h0001);
    chk("t5_bitmap", {8'd0, bitmap}, 16'h0099);
    chk("t5_attr_stale", {8'd0, attr}, 16'h0066);
    step(); underrun_clr = 1'b0;
    chk("t5_underrun_clr", {15'd0, underrun}, 16'h0000);
    video_read_req_ack = 1'b1;
    step();
    video_read_req_ack = 1'b0; video_data_valid = 1'b1; vd = 8'h12;
    step();
    video_data_valid = 1'b0;

    // Reset asserted while waiting in UP_INK.
    fetch_start = 1'b1; up_en = 1'b1;
    step(); fetch_start = 1'b0;
    video_read_req_ack = 1'b1;
    step();
    video_data_valid = 1'b1; vd = 8'h01;
    step();
    video_read_req_ack = 1'b0; vd = 8'h80;
    step();
    video_data_valid = 1'b0;
    step();
    chk("t6_ink_req", {15'd0, video_read_req}, 16'h0001);
    chk("t6_ink_addr", {1'b0, video_read_addr}, 16'h0020);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", {15'd0, video_read_req}, 16'h0000);
    chk("t6_rst_isup", {15'd0, video_read_req_is_up}, 16'h0000);
    chk("t6_rst_addr", {1'b0, video_read_addr}, 16'h0000);
    chk("t6_rst_bitmap", {8'd0, bitmap}, 16'h0000);
    chk("t6_rst_ink", {8'd0, ink_up}, 16'h0000);
    #1 rst = 1'b0;
    video_data_valid = 1'b1; vd = 8'hFF;
    step();
    video_data_valid = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    chk("t6_stray_bitmap", {8'd0, bitmap}, 16'h0000);
    chk("t6_stray_attr", {8'd0, attr}, 16'h0000);
    chk("t6_idle_load_underrun", {15'd0, underrun}, 16'h0001);
    chk("t6_idle_req", {15'd0, video_read_req}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
